// File: rtl/led_sequencer.sv
// led_sequencer: steps a bank of LEDs through a programmable pattern table,
// holding each pattern for DIV = FREQUENCY/1000*STEP_TIME_MS clock cycles.
//   clk_i    system clock
//   rst_ni   synchronous reset, active low
//   wr_i     pattern table write strobe (any state)
//   waddr_i  table write address
//   wdata_i  table write data, bit=1 means LED on
//   start_i  start pulse; len_i/loop_i sampled with it
//   stop_i   abort pulse, wins over start and over the final tick
//   len_i    number of steps to play (1..STEPS)
//   loop_i   1 = repeat forever
//   leds_o   current LED drive (0 when idle)
//   step_o   index of current step
//   busy_o   sequence running
//   done_o   1-cycle pulse on natural completion
module led_sequencer #(
   parameter int FREQUENCY    = 25000000,
   parameter int STEP_TIME_MS = 250,
   parameter int LEDS         = 4,
   parameter int STEPS        = 8,
   localparam int AW          = $clog2(STEPS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wr_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [LEDS-1:0] wdata_i,
   input  logic            start_i,
   input  logic            stop_i,
   input  logic [AW:0]     len_i,
   input  logic            loop_i,
   output logic [LEDS-1:0] leds_o,
   output logic [AW-1:0]   step_o,
   output logic            busy_o,
   output logic            done_o
);
   localparam int DIV = FREQUENCY / 1000 * STEP_TIME_MS;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(STEPS);
   localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   step_q, step_d;
   logic [AW:0]     len_q, len_d;
   logic            loop_q, loop_d;
   logic            done_q, done_d;
   logic [LEDS-1:0] table_q [STEPS];
   logic [LEDS-1:0] table_d [STEPS];

   logic tick, last, len_ok;

   assign tick   = cnt_q == CNT_LAST;
   // len_q is at least 1 whenever RUN is active, so the subtraction cannot wrap
   assign last   = {1'b0, step_q} == len_q - LEN_ONE;
   assign len_ok = len_i != '0 && len_i <= LEN_MAX;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      len_d   = len_q;
      loop_d  = loop_q;
      done_d  = 1'b0;
      table_d = table_q;
      if (wr_i) table_d[waddr_i] = wdata_i;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (start_i && !stop_i && len_ok) begin
            state_d = RUN;
            len_d   = len_i;
            loop_d  = loop_i;
            step_d  = '0;
         end
      end else if (stop_i) begin
         state_d = IDLE;
         step_d  = '0;
         cnt_d   = '0;
      end else begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
         if (tick) begin
            step_d  = last ? '0 : step_q + AW'(1);
            state_d = (last && !loop_q) ? IDLE : RUN;
            done_d  = last && !loop_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
         table_q <= table_d;
      end
   end

   assign busy_o = state_q == RUN;
   assign leds_o = busy_o ? table_q[step_q] : '0;
   assign step_o = step_q;
   assign done_o = done_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized and directed checks of led_sequencer against an elapsed-time model.
module tb_led_sequencer;
   localparam int DIV = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       wr_i = 1'b0;
   logic [2:0] waddr_i = '0;
   logic [3:0] wdata_i = '0;
   logic       start_i = 1'b0;
   logic       stop_i = 1'b0;
   logic [3:0] len_i = '0;
   logic       loop_i = 1'b0;
   logic [3:0] leds_o;
   logic [2:0] step_o;
   logic       busy_o;
   logic       done_o;

   int checks = 0;
   int errors = 0;

   led_sequencer #(.FREQUENCY(4000), .STEP_TIME_MS(1), .LEDS(4), .STEPS(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_i(wr_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .start_i(start_i), .stop_i(stop_i), .len_i(len_i), .loop_i(loop_i),
      .leds_o(leds_o), .step_o(step_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: tracks cycles elapsed since start; the step is elapsed/DIV.
   logic [3:0] m_tab [8];
   logic       m_busy = 1'b0, m_done = 1'b0, m_loop = 1'b0;
   int         m_el = 0, m_len = 0;

   always @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < 8; i++) m_tab[i] <= '0;
         m_busy <= 1'b0; m_done <= 1'b0; m_el <= 0; m_len <= 0; m_loop <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (wr_i) m_tab[waddr_i] <= wdata_i;
         if (!m_busy) begin
            if (start_i && !stop_i && len_i >= 1 && len_i <= 8) begin
               m_busy <= 1'b1; m_el <= 0; m_len <= int'(len_i); m_loop <= loop_i;
            end
         end else if (stop_i) begin
            m_busy <= 1'b0; m_el <= 0;
         end else if (!m_loop && m_el == m_len * DIV - 1) begin
            m_busy <= 1'b0; m_el <= 0; m_done <= 1'b1;
         end else begin
            m_el <= (m_el + 1) % (m_len * DIV);
         end
      end
   end

   logic [3:0] e_leds;
   logic [2:0] e_step;
   assign e_leds = m_busy ? m_tab[m_el / DIV] : 4'h0;
   assign e_step = m_busy ? 3'(m_el / DIV) : 3'd0;

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write(input int a, input logic [3:0] d);
      wr_i = 1'b1; waddr_i = 3'(a); wdata_i = d;
      cycle();
      wr_i = 1'b0;
   endtask

   task automatic start(input int len, input logic lp);
      start_i = 1'b1; len_i = 4'(len); loop_i = lp;
      cycle();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) cycle();
      rst_ni = 1'b1;
      checks++;
      if ({leds_o, step_o, busy_o, done_o} !== 9'h0) begin
         errors++; $display("FAIL reset got=%h exp=0", {leds_o, step_o, busy_o, done_o});
      end
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== 9'h0) begin
            errors++; $display("FAIL idle cyc=%0d got=%h exp=0", i, {leds_o, step_o, busy_o, done_o});
         end
      end
   endtask

   task automatic test_one_shot();
      logic [3:0] seq [3] = '{4'h1, 4'h3, 4'h8};
      int dones = 0;
      write(0, 4'h1); write(1, 4'h3); write(2, 4'h8);
      start(3, 1'b0);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== {seq[i / 4], 3'(i / 4), 1'b1, 1'b0}) begin
            errors++; $display("FAIL one_shot cyc=%0d got=%h exp=%h", i, {leds_o, step_o, busy_o, done_o}, {seq[i / 4], 3'(i / 4), 1'b1, 1'b0});
         end
         cycle();
      end
      for (int i = 0; i < 3; i++) begin
         dones += int'(done_o);
         checks++;
         if ({leds_o, busy_o} !== 5'h0) begin
            errors++; $display("FAIL one_shot_end cyc=%0d got=%h exp=0", i, {leds_o, busy_o});
         end
         cycle();
      end
      checks++;
      if (dones != 1) begin
         errors++; $display("FAIL one_shot_done got=%0d exp=1", dones);
      end
   endtask

   task automatic test_loop_stop();
      start(2, 1'b1);
      for (int i = 0; i < 40; i++) begin
         checks++;
         if ({leds_o, busy_o, done_o} !== {((i / 4) % 2 == 1) ? 4'h3 : 4'h1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL loop cyc=%0d got=%h", i, {leds_o, busy_o, done_o});
         end
         cycle();
      end
      stop_i = 1'b1; cycle(); stop_i = 1'b0;
      checks++;
      if ({leds_o, busy_o, done_o} !== 6'h0) begin
         errors++; $display("FAIL stop got=%h exp=0", {leds_o, busy_o, done_o});
      end
      cycle();
      checks++;
      if (done_o !== 1'b0) begin
         errors++; $display("FAIL stop_done got=%b exp=0", done_o);
      end
   endtask

   task automatic test_illegal();
      start(0, 1'b0);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL len0 busy got=%b exp=0", busy_o);
      end
      start(9, 1'b1);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL len9 busy got=%b exp=0", busy_o);
      end
      for (int i = 0; i < 8; i++) write(i, 4'($urandom));
      start(int'($urandom_range(3, 8)), 1'b0);
      for (int i = 0; i < 36; i++) begin
         if (i == 5) begin
            start_i = 1'b1; len_i = 4'($urandom_range(1, 8)); loop_i = 1'b1;
         end
         cycle();
         start_i = 1'b0;
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== {e_leds, e_step, m_busy, m_done}) begin
            errors++; $display("FAIL start_in_run cyc=%0d got=%h exp=%h", i, {leds_o, step_o, busy_o, done_o}, {e_leds, e_step, m_busy, m_done});
         end
      end
   endtask

   task automatic test_boundary();
      int dones = 0;
      for (int i = 0; i < 8; i++) write(i, 4'($urandom));
      start(8, 1'b0);
      for (int i = 0; i < 34; i++) begin
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== {e_leds, e_step, m_busy, m_done}) begin
            errors++; $display("FAIL len8 cyc=%0d got=%h exp=%h", i, {leds_o, step_o, busy_o, done_o}, {e_leds, e_step, m_busy, m_done});
         end
         dones += int'(done_o);
         cycle();
      end
      checks++;
      if (dones != 1) begin
         errors++; $display("FAIL len8_done got=%0d exp=1", dones);
      end
      start(2, 1'b0);
      repeat (7) cycle();
      stop_i = 1'b1; cycle(); stop_i = 1'b0;
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++; $display("FAIL stop_final got=%b exp=00", {busy_o, done_o});
      end
      cycle();
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++; $display("FAIL stop_final_next got=%b exp=00", {busy_o, done_o});
      end
      stop_i = 1'b1; start(4, 1'b1); stop_i = 1'b0;
      checks++;
      if ({leds_o, busy_o} !== 5'h0) begin
         errors++; $display("FAIL start_stop_idle got=%h exp=0", {leds_o, busy_o});
      end
   endtask

   task automatic test_live_write();
      for (int i = 0; i < 4; i++) write(i, 4'($urandom_range(0, 14)));
      start(4, 1'b1);
      repeat (5) cycle();
      write(1, 4'hF);
      checks++;
      if ({leds_o, step_o} !== {4'hF, 3'd1}) begin
         errors++; $display("FAIL live_write got=%h exp=%h", {leds_o, step_o}, {4'hF, 3'd1});
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== {e_leds, e_step, m_busy, m_done}) begin
            errors++; $display("FAIL live_timing cyc=%0d got=%h exp=%h", i, {leds_o, step_o, busy_o, done_o}, {e_leds, e_step, m_busy, m_done});
         end
         cycle();
      end
      rst_ni = 1'b0; cycle(); rst_ni = 1'b1;
      checks++;
      if ({leds_o, step_o, busy_o, done_o} !== 9'h0) begin
         errors++; $display("FAIL mid_reset got=%h exp=0", {leds_o, step_o, busy_o, done_o});
      end
      start(8, 1'b0);
      for (int i = 0; i < 33; i++) begin
         checks++;
         if ({leds_o, done_o} !== {4'h0, i == 32}) begin
            errors++; $display("FAIL table_cleared cyc=%0d got=%h", i, {leds_o, done_o});
         end
         cycle();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_i = $urandom_range(0, 3) == 0; waddr_i = 3'($urandom); wdata_i = 4'($urandom);
         start_i = $urandom_range(0, 15) == 0; stop_i = $urandom_range(0, 39) == 0;
         len_i = 4'($urandom); loop_i = 1'($urandom);
         cycle();
         checks++;
         if ({leds_o, step_o, busy_o, done_o} !== {e_leds, e_step, m_busy, m_done}) begin
            errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, {leds_o, step_o, busy_o, done_o}, {e_leds, e_step, m_busy, m_done});
         end
      end
      {wr_i, start_i, stop_i} = 3'b000;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_loop_stop();
      test_illegal();
      test_boundary();
      test_live_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Time-multiplexed LED pattern controller. Steps a bank of LEDS outputs through a programmable table of up to STEPS patterns. Each pattern is held for a fixed step period derived from FREQUENCY by an internal prescaler. Sits between host/config logic and board LEDs; it is the generalisation of the single-LED blink divider.

Parameters:
FREQUENCY, 25000000, clk_i frequency in Hz
STEP_TIME_MS, 250, duration of one pattern step in ms
LEDS, 4, number of LED outputs (1..32)
STEPS, 8, pattern table depth (power of 2, >=2)
(derived) DIV = FREQUENCY/1000*STEP_TIME_MS, must be >=1; AW = $clog2(STEPS)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous reset, active low
wr_i  in  1  pattern table write strobe
waddr_i  in  AW  table write address
wdata_i  in  LEDS  table write data (bit=1 LED on)
start_i  in  1  start sequence (1-cycle pulse)
stop_i  in  1  abort sequence (1-cycle pulse)
len_i  in  AW+1  number of steps to play, sampled with start_i
loop_i  in  1  1=repeat forever, sampled with start_i
leds_o  out  LEDS  current LED drive
step_o  out  AW  index of current step
busy_o  out  1  sequence running
done_o  out  1  1-cycle pulse on natural completion

Behaviour:
- Single clock domain. All state updates on posedge clk_i.
- Reset (rst_ni=0 at a clock edge):
  - table cleared to 0; state IDLE; prescaler cnt=0; step=0; len/loop regs=0.
  - Outputs: leds_o=0, step_o=0, busy_o=0, done_o=0.
  - Reset mid-RUN aborts immediately, with no done_o pulse.
- Pattern table: STEPS x LEDS registers. Write when wr_i=1, in any state. Value visible on reads the following cycle.
- leds_o = busy_o ? table[step] : 0. Derived from registers only; no combinational path from inputs.
- States:
  - IDLE:
    - cnt held at 0.
    - start_i=1 with 1 <= len_i <= STEPS: latch len_i and loop_i, step=0, cnt=0, go to RUN.
    - start_i with len_i=0 or len_i>STEPS is ignored; stay in IDLE.
  - RUN:
    - busy_o=1. cnt counts 0..DIV-1 and wraps. tick = (cnt==DIV-1). Each step lasts exactly DIV cycles.
    - On tick, step < len-1: step <= step+1.
    - On tick, step == len-1, loop=1: step <= 0; stay in RUN.
    - On tick, step == len-1, loop=0: go to IDLE, step <= 0, done_o=1 for one cycle (the first IDLE cycle).
    - stop_i=1: go to IDLE next cycle, step <= 0, cnt <= 0, no done_o.
    - start_i in RUN is ignored, including the parameters sampled with it.
- Simultaneous events:
  - stop_i and start_i in the same cycle: stop wins; in IDLE, both are ignored.
  - stop_i coincident with the final tick: stop wins, no done_o.
  - wr_i to the current step in RUN: leds_o changes on the next cycle, without disturbing timing.
- From the start_i cycle, leds_o shows table[0] on the next cycle. Total run with loop=0 is len*DIV cycles of busy_o=1.
- Width rules:
  - cnt width $clog2(DIV+1); no overflow possible.
  - len compare uses AW+1 bits, so len=STEPS is legal.
  - DIV=1 gives a tick every cycle.

Test Plan:
Use FREQUENCY=4000, STEP_TIME_MS=1 (DIV=4), LEDS=4, STEPS=8.
1. Reset/idle: hold rst_ni=0 for 3 cycles, then release -> leds_o=0, busy_o=0, step_o=0, done_o=0; no output change for 20 idle cycles.
2. One-shot: write table[0..2]=4'h1,4'h3,4'h8; start_i with len_i=3, loop_i=0 -> leds_o sequence 1,3,8 each held exactly 4 cycles, busy_o=1 for 12 cycles, done_o pulses once, then leds_o=0.
3. Loop and stop: same table, len_i=2, loop_i=1 -> leds_o alternates 1,3 every 4 cycles for 5 periods; pulse stop_i -> next cycle busy_o=0, leds_o=0, no done_o.
4. Illegal and ignored starts: start_i with len_i=0 -> stays IDLE. start_i with len_i=9 -> stays IDLE. start_i during RUN -> sequence continues unchanged.
5. Boundary and collision: len_i=8 plays all 8 entries then done_o. stop_i coincident with the final tick -> no done_o. start_i+stop_i together in IDLE -> stays IDLE.
6. Live write and reset: during RUN, write the current step with 4'hF -> leds_o=F next cycle, step timing unchanged. Assert rst_ni mid-RUN -> all outputs 0 next cycle, table reads back 0.
